// File: rtl/rvfi_seq_pkg.sv
// Shared types and helpers for the RVFI check sequencer.
package rvfi_seq_pkg;

  localparam int ORDER_W  = 64;
  // Widest retire bus the popcount helper handles; callers zero-extend.
  localparam int MAX_NRET = 64;

  typedef enum logic [2:0] {
    RST,
    MONITOR,
    DONE,
    MISSED,
    TIMEOUT
  } seq_state_t;

  // Number of set bits in a (zero-extended) per-channel vector.
  function automatic int unsigned popcount_nret(input logic [MAX_NRET-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_NRET; i++) begin
      cnt = cnt + {31'b0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rvfi_order_match.sv
// Per-channel order compare against the target, lowest-channel priority
// encode, and a flag for more than one channel matching in the same beat.
module rvfi_order_match
  import rvfi_seq_pkg::*;
#(
  parameter int NRET = 1,
  parameter int CH_W = 1
) (
  input  logic [NRET-1:0]         i_valid,
  input  logic [ORDER_W*NRET-1:0] i_order,
  input  logic [ORDER_W-1:0]      i_target,
  output logic                    o_hit,
  output logic [CH_W-1:0]         o_ch,
  output logic                    o_multi
);

  logic [NRET-1:0] w_hit_vec;
  logic            w_found;

  // Full-width unsigned compare of every valid channel against the target.
  always_comb begin
    w_hit_vec = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      w_hit_vec[i] = i_valid[i] && (i_order[i*ORDER_W +: ORDER_W] == i_target);
    end
  end

  // Lowest matching channel wins.
  always_comb begin
    o_ch    = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NRET; i++) begin
      if (w_hit_vec[i] && !w_found) begin
        o_ch    = CH_W'(i);
        w_found = 1'b1;
      end
    end
  end

  assign o_hit   = |w_hit_vec;
  assign o_multi = popcount_nret(MAX_NRET'(w_hit_vec)) > 1;

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Sequences one formal consistency checker against the RVFI stream: holds the
// checker in reset for a fixed window, then pulses check in the exact beat the
// target instruction retires, bounding the run and flagging error outcomes.
module rvfi_check_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int NRET         = 1,
  parameter int RESET_CYCLES = 1,
  parameter int MIN_CYCLES   = 0,
  parameter int MAX_CYCLES   = 20,
  localparam int CH_W        = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [ORDER_W*NRET-1:0] rvfi_order,
  input  logic [ORDER_W-1:0]      target_order,
  output logic                    checker_reset,
  output logic                    check,
  output logic [CH_W-1:0]         check_channel,
  output logic                    done,
  output logic                    missed,
  output logic                    timeout,
  output logic                    dup_err,
  output logic [15:0]             retire_count
);

  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int PC_W  = $clog2(NRET + 1);

  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

  seq_state_t       r_state;
  logic [RST_W-1:0] r_rst_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [15:0]      r_retire_count;
  logic             r_checker_reset;
  logic             r_done;
  logic             r_missed;
  logic             r_timeout;
  logic             r_dup_err;

  logic             w_hit;
  logic [CH_W-1:0]  w_ch;
  logic             w_multi;
  logic             w_early;
  logic             w_check;
  logic [PC_W-1:0]  w_valid_cnt;
  logic [16:0]      w_rc_sum;
  logic [15:0]      w_rc_next;

  rvfi_order_match #(
    .NRET (NRET),
    .CH_W (CH_W)
  ) u_match (
    .i_valid  (rvfi_valid),
    .i_order  (rvfi_order),
    .i_target (target_order),
    .o_hit    (w_hit),
    .o_ch     (w_ch),
    .o_multi  (w_multi)
  );

  // With no minimum every monitor cycle is acceptable; avoids a constant compare.
  generate
    if (MIN_CYCLES == 0) begin : g_nomin
      assign w_early = 1'b0;
    end else begin : g_min
      assign w_early = (r_cycle_cnt < CNT_W'(MIN_CYCLES));
    end
  endgenerate

  assign w_check     = (r_state == MONITOR) && w_hit && !w_early;
  assign w_valid_cnt = PC_W'(popcount_nret(MAX_NRET'(rvfi_valid)));
  assign w_rc_sum    = {1'b0, r_retire_count} + 17'(w_valid_cnt);
  assign w_rc_next   = w_rc_sum[16] ? 16'hFFFF : w_rc_sum[15:0];

  // Sequencer FSM with its counters and sticky outcome flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state         <= RST;
      r_rst_cnt       <= '0;
      r_cycle_cnt     <= '0;
      r_retire_count  <= '0;
      r_checker_reset <= 1'b1;
      r_done          <= 1'b0;
      r_missed        <= 1'b0;
      r_timeout       <= 1'b0;
      r_dup_err       <= 1'b0;
    end else begin
      case (r_state)
        RST: begin
          if (r_rst_cnt == RST_LAST) begin
            r_state         <= MONITOR;
            r_checker_reset <= 1'b0;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        MONITOR: begin
          if (r_cycle_cnt != MAX_C) r_cycle_cnt <= r_cycle_cnt + 1'b1;
          r_retire_count <= w_rc_next;
          if (w_multi) r_dup_err <= 1'b1;
          if (w_hit && w_early) begin
            r_state  <= MISSED;
            r_missed <= 1'b1;
          end else if (w_hit) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (r_cycle_cnt == LAST_C) begin
            r_state   <= TIMEOUT;
            r_timeout <= 1'b1;
          end
        end
        DONE, MISSED, TIMEOUT: ;
        default: r_state <= RST;
      endcase
    end
  end

  assign checker_reset = r_checker_reset;
  assign check         = w_check;
  assign check_channel = w_check ? w_ch : '0;
  assign done          = r_done;
  assign missed        = r_missed;
  assign timeout       = r_timeout;
  assign dup_err       = r_dup_err;
  assign retire_count  = r_retire_count;

endmodule
